// File: rtl/song_reader.sv
// song_reader: walks a song ROM and hands each note/duration to the note player
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          note_done,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                   rom_data,
    output logic [5:0]                    note_to_load,
    output logic [5:0]                    duration,
    output logic                          load_new_note,
    output logic                          song_done
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOAD, WAIT_DONE, DONE} state_t;

    state_t               state_q, state_d;
    logic [NOTE_BITS-1:0] index_q, index_d;
    logic [SONG_BITS-1:0] song_sel_q, song_sel_d;
    logic                 armed_q, armed_d;
    logic [5:0]           note_q, note_d;
    logic [5:0]           dur_q, dur_d;

    // Next state: a song change restarts the sequence; otherwise advance only while playing.
    // armed stops the sequencer from acting on the stale note_done the player holds right after a load.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        song_sel_d = song_sel_q;
        armed_d    = armed_q;
        note_d     = note_q;
        dur_d      = dur_q;
        if (song != song_sel_q) begin
            song_sel_d = song;
            index_d    = '0;
            armed_d    = 1'b0;
            state_d    = IDLE;
        end else if (play) begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = CAPTURE;
                CAPTURE: begin
                    if (rom_data[5:0] == 6'd0) begin
                        state_d = DONE;
                    end else begin
                        note_d  = rom_data[11:6];
                        dur_d   = rom_data[5:0];
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    armed_d = 1'b0;
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!note_done) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        if (&index_q) begin
                            state_d = DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State registers; reset picks up the currently selected song so no spurious restart follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            song_sel_q <= song;
            armed_q    <= 1'b0;
            note_q     <= '0;
            dur_q      <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            song_sel_q <= song_sel_d;
            armed_q    <= armed_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
        end
    end

    assign rom_addr      = {song_sel_q, index_q};
    assign note_to_load  = note_q;
    assign duration      = dur_q;
    assign load_new_note = play && (state_q == LOAD);
    assign song_done     = (state_q == DONE);
endmodule
